ap_ctrl_hs_driver: RTL and testbench
====================================

# ap_ctrl_hs_driver

Synthesizable initiator for the Vitis `ap_ctrl_hs` block-level handshake. It issues a programmed number of kernel transactions by driving `ap_start` and consuming `ap_ready`/`ap_done`, and allows overlapped (pipelined) transactions up to a bounded depth. It measures per-transaction start-to-done latency in hardware. It sits between a host/config register block and the kernel top, and plays the driving side of the handshake that the simulation dataflow monitors only observe.

## Interface
- `TXN_W`, 16: width of transaction count.
- `CNT_W`, 32: width of cycle counter and latency outputs.
- `MAX_OUT`, 4: maximum outstanding (accepted, not done) transactions; power of two, ≥1.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `cfg_go` in 1: one-cycle start pulse, sampled only in IDLE.
- `cfg_num_txn` in TXN_W: transactions to issue; sampled with `cfg_go`.
- `ap_start` out 1: kernel start request.
- `ap_ready` in 1: kernel accepted the current start.
- `ap_done` in 1: one transaction completed (one-cycle pulse per transaction).
- `busy` out 1: high in RUN or DRAIN.
- `all_done` out 1: one-cycle pulse when the run completes.
- `txn_started` out TXN_W: accepted starts in the current run.
- `txn_done` out TXN_W: completions in the current run.
- `last_latency` out CNT_W: latency of the most recent completion.
- `max_latency` out CNT_W: maximum latency in the current run.
- `total_cycles` out CNT_W: cycles from `cfg_go` to `all_done`.
- `protocol_err` out 1: sticky flag. Set on `ap_done` with no outstanding transaction. Cleared by the next accepted `cfg_go`.

## Operation
- The FSM has three states: IDLE, RUN, DRAIN.
- IDLE → RUN on `cfg_go`. On entry, latch `cfg_num_txn`, clear the counters, `max_latency`, `protocol_err` and the cycle counter.
- If `cfg_num_txn==0`, IDLE stays IDLE and `all_done` pulses the next cycle with `total_cycles=1`.
- Acceptance: a start is accepted when `ap_start & ap_ready`. On acceptance, increment `txn_started` and push the start timestamp.
- The start timestamp is the cycle-counter value in the first cycle `ap_start` was high for that transaction.
- `ap_start` is a register. It is high in RUN iff `txn_started < num` and `outstanding < MAX_OUT`, both evaluated on next-state values.
- `ap_start` is held high until acceptance. It never drops without `ap_ready`.
- RUN → DRAIN when `txn_started` reaches `num`.
- DRAIN → IDLE when `txn_done` reaches `num`. `all_done` pulses on the transition and `total_cycles` latches.
- On `ap_done` with outstanding > 0:
  - Pop the FIFO.
  - `latency = cycle_cnt − timestamp`, computed modulo 2^CNT_W.
  - Update `last_latency`, increment `txn_done`, and set `max_latency = max(max_latency, latency)`.
- Bypass case: `ap_done` in the same cycle as an acceptance with the FIFO empty uses the accepting transaction's timestamp.
- Same-cycle push and pop is legal; occupancy is unchanged.
- `ap_done` with no outstanding transaction and no bypass sets `protocol_err`. Counters are unchanged.
- `ap_ready` without `ap_start` is ignored.
- `cfg_go` outside IDLE is ignored.
- `cycle_cnt` is free-running from `cfg_go`. It wraps; there is no saturation.

## Timing
- All outputs reset to 0. The FSM resets to IDLE and the FIFO resets to empty.
- Reset mid-run aborts immediately. No `all_done` pulse is produced.
- `ap_start` rises the cycle after `cfg_go`.
- Back-to-back starts: when `ap_ready` is high every cycle and depth is available, one start is accepted per cycle.
- When `outstanding == MAX_OUT`, `ap_start` is low. It re-rises the cycle after an `ap_done` frees a slot.
- Output timing after an `ap_done` edge:
  - `last_latency`, `max_latency` and `txn_done` update one cycle after the `ap_done` edge.
  - `all_done` is high the cycle after the final `ap_done`.

## Structure
- Package `ap_ctrl_pkg` holds:
  - the `fsm_e` enum (IDLE, RUN, DRAIN);
  - the default width localparams.
- Sub-module `ts_fifo`: a synchronous FIFO with `MAX_OUT` entries of CNT_W bits. It supports simultaneous push/pop and provides `empty`, `full` and `count`.
- Outstanding count = `ts_fifo.count`.

## Test plan
- Sequential kernel: num=3, `ap_ready` one cycle after `ap_start`, `ap_done` 10 cycles after acceptance → three starts, `last_latency=11` each, `max_latency=11`, one `all_done`, `busy` low after.
- Pipelined kernel with `ap_ready` tied high and `ap_done` 5 cycles after acceptance, num=8, MAX_OUT=4 → `ap_start` high 4 consecutive cycles, then stalls until the first done. Every latency is 5. `all_done` follows the 8th done.
- num=0 → `all_done` the cycle after `cfg_go`, `ap_start` never high, `total_cycles=1`.
- Spurious `ap_done` in IDLE → `protocol_err=1`, counters stay 0. The next `cfg_go` clears it.
- Same-cycle `ap_ready` and `ap_done` with an empty FIFO → `last_latency` equals the `ap_start` hold time, and `protocol_err` stays 0.
- Assert `reset` in DRAIN with 2 outstanding → all outputs 0 asynchronously and no `all_done`. A subsequent run with num=1 behaves normally.

Source files
------------

// File: rtl/ap_ctrl_hs_driver_pkg.sv
// Shared types and default widths for the ap_ctrl_hs initiator.
package ap_ctrl_pkg;

  localparam int DEF_TXN_W   = 16;
  localparam int DEF_CNT_W   = 32;
  localparam int DEF_MAX_OUT = 4;

  // Run-level FSM: waiting for a go, issuing starts, waiting for the tail of dones.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fsm_e;

endpackage

// File: rtl/ap_ctrl_hs_driver_if.sv
// Block-level ap_ctrl_hs handshake between the initiator (master) and the kernel (slave).
//
// Handshake rules: ap_start is the request and stays high until the kernel
// answers with ap_ready in the same cycle; a start is accepted exactly on a
// cycle where ap_start & ap_ready. ap_ready while ap_start is low means
// nothing. ap_done is a one-cycle pulse, one per accepted start, in order.
interface ap_ctrl_hs_driver_if;
  logic ap_start;
  logic ap_ready;
  logic ap_done;

  modport master (output ap_start, input ap_ready, input ap_done);
  modport slave  (input ap_start, output ap_ready, output ap_done);
endinterface

// File: rtl/ap_ctrl_hs_driver_ts_fifo.sv
// Timestamp FIFO: one entry per accepted-but-not-done transaction.
// Supports push and pop in the same cycle, including when full.
module ts_fifo
  import ap_ctrl_pkg::*;
#(
  parameter int  DEPTH = DEF_MAX_OUT,
  parameter int  W     = DEF_CNT_W,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [W-1:0]  i_data,
  output logic [W-1:0]  o_data,
  output logic          o_empty,
  output logic          o_full,
  output logic [CW-1:0] o_count
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_do_push;
  logic          w_do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CW'(DEPTH));
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage write; contents are only meaningful below r_count, so no reset.
  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator: issues a programmed number of kernel starts with up to
// MAX_OUT overlapped, and measures start-to-done latency per transaction.
module ap_ctrl_hs_driver
  import ap_ctrl_pkg::*;
#(
  parameter int TXN_W   = DEF_TXN_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int MAX_OUT = DEF_MAX_OUT
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cfg_go,
  input  logic [TXN_W-1:0]     cfg_num_txn,
  ap_ctrl_hs_driver_if.master  hs,
  output logic                 busy,
  output logic                 all_done,
  output logic [TXN_W-1:0]     txn_started,
  output logic [TXN_W-1:0]     txn_done,
  output logic [CNT_W-1:0]     last_latency,
  output logic [CNT_W-1:0]     max_latency,
  output logic [CNT_W-1:0]     total_cycles,
  output logic                 protocol_err,
  output logic [1:0]           dbg_state
);

  localparam int CW = $clog2(MAX_OUT + 1);

  fsm_e             r_state;
  logic [TXN_W-1:0] r_num;
  logic [TXN_W-1:0] r_started;
  logic [TXN_W-1:0] r_done;
  logic [CNT_W-1:0] r_last_lat;
  logic [CNT_W-1:0] r_max_lat;
  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic [CNT_W-1:0] r_start_ts;
  logic             r_err;
  logic             r_all_done;
  logic             r_ap_start;

  fsm_e             w_state_next;
  logic             w_finish;
  logic             w_go;
  logic             w_accept;
  logic             w_bypass;
  logic             w_push;
  logic             w_pop;
  logic             w_complete;
  logic             w_spurious;
  logic             w_start_next;
  logic             w_empty;
  logic             w_full;
  logic [CW-1:0]    w_count;
  logic [CW-1:0]    w_count_next;
  logic [CNT_W-1:0] w_head;
  logic [CNT_W-1:0] w_latency;
  logic [CNT_W-1:0] w_cnt_next;
  logic [TXN_W-1:0] w_started_next;
  logic [TXN_W-1:0] w_done_next;

  ts_fifo #(.DEPTH(MAX_OUT), .W(CNT_W)) u_ts_fifo (
    .i_clk   (clock),
    .i_rst   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (r_start_ts),
    .o_data  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full),
    .o_count (w_count)
  );

  // A done that lands on the very cycle its own start is accepted (FIFO empty)
  // never enters the FIFO; it is timed from the live start timestamp instead.
  assign w_go           = cfg_go && (r_state == IDLE);
  assign w_accept       = r_ap_start && hs.ap_ready;
  assign w_bypass       = hs.ap_done && w_accept && w_empty;
  assign w_push         = w_accept && !w_bypass && (!w_full || w_pop);
  assign w_pop          = hs.ap_done && !w_empty;
  assign w_complete     = w_pop || w_bypass;
  assign w_spurious     = hs.ap_done && !w_complete;
  assign w_latency      = r_cycle_cnt - (w_bypass ? r_start_ts : w_head);
  assign w_started_next = r_started + TXN_W'(w_accept);
  assign w_done_next    = r_done + TXN_W'(w_complete);
  assign w_count_next   = w_count + CW'(w_push) - CW'(w_pop);
  // The cycle after go reads 1, so total_cycles is just the counter's next value.
  assign w_cnt_next     = w_go ? CNT_W'(1) : r_cycle_cnt + CNT_W'(1);

  // Staying in RUN already implies starts remain, so only depth gates the request.
  assign w_start_next   = (w_state_next == RUN) && (w_count_next < CW'(MAX_OUT));

  assign hs.ap_start    = r_ap_start;
  assign busy           = (r_state != IDLE);
  assign all_done       = r_all_done;
  assign txn_started    = r_started;
  assign txn_done       = r_done;
  assign last_latency   = r_last_lat;
  assign max_latency    = r_max_lat;
  assign total_cycles   = r_total;
  assign protocol_err   = r_err;
  assign dbg_state      = r_state;

  // Next-state decode; w_finish marks the edge that ends a run.
  always_comb begin
    w_state_next = r_state;
    w_finish     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cfg_go) begin
          if (cfg_num_txn == '0) w_finish = 1'b1;
          else                   w_state_next = RUN;
        end
      end
      RUN, DRAIN: begin
        if (w_done_next == r_num) begin
          w_state_next = IDLE;
          w_finish     = 1'b1;
        end else if (w_started_next == r_num) begin
          w_state_next = DRAIN;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM, start request, cycle counter, timestamp capture and run completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_ap_start  <= 1'b0;
      r_cycle_cnt <= '0;
      r_start_ts  <= '0;
      r_all_done  <= 1'b0;
      r_total     <= '0;
      r_num       <= '0;
    end else begin
      r_state     <= w_state_next;
      r_ap_start  <= w_start_next;
      r_cycle_cnt <= w_cnt_next;
      r_all_done  <= w_finish;
      if (w_finish) r_total <= w_cnt_next;
      if (w_go)     r_num   <= cfg_num_txn;
      // A new transaction's first request cycle is the next cycle whenever
      // the request is (re)asserted from low or follows an acceptance.
      if (w_start_next && (!r_ap_start || w_accept)) r_start_ts <= w_cnt_next;
    end
  end

  // Per-run statistics and the sticky protocol error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_started  <= '0;
      r_done     <= '0;
      r_last_lat <= '0;
      r_max_lat  <= '0;
      r_err      <= 1'b0;
    end else if (w_go) begin
      r_started <= '0;
      r_done    <= '0;
      r_max_lat <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_accept) r_started <= w_started_next;
      if (w_complete) begin
        r_done     <= w_done_next;
        r_last_lat <= w_latency;
        if (w_latency > r_max_lat) r_max_lat <= w_latency;
      end
      if (w_spurious) r_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ap_ctrl_hs_driver.sv
// Directed and randomized bench for ap_ctrl_hs_driver with a cycle-level kernel model.
module tb_ap_ctrl_hs_driver;
  import ap_ctrl_pkg::*;

  localparam int TXN_W   = 16;
  localparam int CNT_W   = 32;
  localparam int MAX_OUT = 4;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_go = 1'b0;
  logic [TXN_W-1:0] cfg_num_txn = '0;
  logic             busy;
  logic             all_done;
  logic [TXN_W-1:0] txn_started;
  logic [TXN_W-1:0] txn_done;
  logic [CNT_W-1:0] last_latency;
  logic [CNT_W-1:0] max_latency;
  logic [CNT_W-1:0] total_cycles;
  logic             protocol_err;
  logic [1:0]       dbg_state;

  ap_ctrl_hs_driver_if hs();

  ap_ctrl_hs_driver #(.TXN_W(TXN_W), .CNT_W(CNT_W), .MAX_OUT(MAX_OUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .cfg_go       (cfg_go),
    .cfg_num_txn  (cfg_num_txn),
    .hs           (hs),
    .busy         (busy),
    .all_done     (all_done),
    .txn_started  (txn_started),
    .txn_done     (txn_done),
    .last_latency (last_latency),
    .max_latency  (max_latency),
    .total_cycles (total_cycles),
    .protocol_err (protocol_err),
    .dbg_state    (dbg_state)
  );

  always #5 clock = ~clock;

  // ---------------- scoreboard / model state ----------------
  int               n_assert = 0;
  int               n_fail   = 0;
  int               cyc      = 0;
  int               num      = 0;
  int               acc_cnt  = 0;
  int               done_cnt = 0;
  int               go_cyc   = 0;
  int               first_cyc = 0;
  bit               have_first = 0;
  bit               running  = 0;
  bit               exp_all  = 0;
  bit               exp_err  = 0;
  bit               last_valid = 0;
  logic [CNT_W-1:0] exp_last = '0;
  logic [CNT_W-1:0] exp_max  = '0;
  logic [CNT_W-1:0] exp_q[$];     // expected latencies, in completion order
  int               done_q[$];    // cycles on which the kernel will pulse ap_done
  int               rdy_mode = 0; // 0 tied high, 1 fixed wait after start, 2 random
  int               rdy_delay = 0;
  int               dly_min = 0;
  int               dly_max = 0;
  bit               go_req = 0;
  logic [TXN_W-1:0] go_num = '0;
  bit               spur_req = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    acc_cnt = 0; done_cnt = 0; num = 0; running = 0; exp_all = 0; exp_err = 0;
    last_valid = 0; exp_last = '0; exp_max = '0; have_first = 0;
    exp_q.delete(); done_q.delete();
  endtask

  // ---------------- driver: one clock cycle of kernel behaviour ----------------
  // Called at a falling edge: decides this cycle's inputs, crosses the rising
  // edge, updates the model and checks the outputs at the next falling edge.
  task automatic cycle();
    bit st, rdy, acc, dn, go_now, spur_now;
    int dcyc;
    st = hs.ap_start;
    if (st && !have_first) begin have_first = 1; first_cyc = cyc; end
    case (rdy_mode)
      0:       rdy = 1'b1;
      1:       rdy = st && ((cyc - first_cyc) >= rdy_delay);
      default: rdy = ($urandom_range(1, 0) == 1);
    endcase
    acc = st && rdy;
    if (acc) begin
      dcyc = cyc + int'($urandom_range(dly_max, dly_min));
      if (done_q.size() > 0 && dcyc <= done_q[$]) dcyc = done_q[$] + 1;
      done_q.push_back(dcyc);
      exp_q.push_back(CNT_W'(dcyc - first_cyc));
      have_first = 0;
    end
    spur_now = spur_req;
    dn = spur_req;
    if (done_q.size() > 0 && done_q[0] == cyc) begin dn = 1; void'(done_q.pop_front()); end
    go_now      = go_req;
    hs.ap_ready = rdy;
    hs.ap_done  = dn;
    cfg_go      = go_req;
    cfg_num_txn = go_num;
    go_req      = 0;
    spur_req    = 0;

    @(posedge clock);
    cyc++;
    exp_all = 0;
    if (go_now) begin
      acc_cnt = 0; done_cnt = 0; exp_max = '0; exp_err = 0; last_valid = 0;
      go_cyc = cyc - 1; num = int'(go_num);
      if (num == 0) exp_all = 1; else running = 1;
    end else begin
      if (acc) acc_cnt++;
      if (spur_now) exp_err = 1;
      else if (dn) begin
        done_cnt++;
        exp_last = exp_q.pop_front();
        if (exp_last > exp_max) exp_max = exp_last;
        last_valid = 1;
        if (running && done_cnt == num) begin running = 0; exp_all = 1; end
      end
    end

    @(negedge clock);
    chk("ap_start", hs.ap_start, running && (acc_cnt < num) && ((acc_cnt - done_cnt) < MAX_OUT));
    chk("busy", busy, running);
    chk("all_done", all_done, exp_all);
    chk("txn_started", txn_started, acc_cnt);
    chk("txn_done", txn_done, done_cnt);
    chk("max_latency", max_latency, exp_max);
    chk("protocol_err", protocol_err, exp_err);
    if (last_valid) chk("last_latency", last_latency, exp_last);
    if (exp_all) chk("total_cycles", total_cycles, 32'(cyc - go_cyc));
  endtask

  task automatic run(input int n, input int rmode, input int rdel,
                     input int dmin, input int dmax, input int limit);
    rdy_mode = rmode; rdy_delay = rdel; dly_min = dmin; dly_max = dmax;
    go_req = 1; go_num = TXN_W'(n);
    cycle();
    for (int i = 0; i < limit && running; i++) cycle();
    chk("run_timeout", running, 0);
    cycle();
    cycle();
  endtask

  // Asserts reset between clock edges and checks the asynchronous clear.
  task automatic apply_reset();
    reset = 1'b1; cfg_go = 1'b0; hs.ap_ready = 1'b0; hs.ap_done = 1'b0;
    #1;
    chk("rst_ap_start", hs.ap_start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_all_done", all_done, 0);
    chk("rst_txn_started", txn_started, 0);
    chk("rst_txn_done", txn_done, 0);
    chk("rst_last_latency", last_latency, 0);
    chk("rst_max_latency", max_latency, 0);
    chk("rst_total_cycles", total_cycles, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_state", dbg_state, 32'(IDLE));
    model_clear();
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      chk("rst_hold_all_done", all_done, 0);
      chk("rst_hold_busy", busy, 0);
    end
    reset = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    hs.ap_ready = 1'b0;
    hs.ap_done  = 1'b0;
    @(negedge clock);
    apply_reset();

    // Spurious done while idle sets the sticky error; counters stay at zero.
    rdy_mode = 0; spur_req = 1;
    cycle();
    cycle();

    // Sequential kernel: ready one cycle after start, done 10 after acceptance.
    run(3, 1, 1, 10, 10, 100);
    chk("seq_max_latency", max_latency, 11);
    chk("seq_last_latency", last_latency, 11);
    chk("seq_txn_done", txn_done, 3);

    // Pipelined kernel: ready tied high, done 5 after acceptance, depth-limited.
    run(8, 0, 0, 5, 5, 100);
    chk("pipe_max_latency", max_latency, 5);
    chk("pipe_txn_done", txn_done, 8);

    // Zero-transaction run.
    run(0, 0, 0, 1, 1, 10);
    chk("zero_total_cycles", total_cycles, 1);

    // Done coincident with acceptance on an empty FIFO, after a 1-cycle hold.
    run(2, 1, 1, 0, 0, 50);
    chk("bypass_last_latency", last_latency, 1);
    chk("bypass_protocol_err", protocol_err, 0);

    // Randomized ready/done behaviour and run lengths.
    for (int r = 0; r < 8; r++) run(int'($urandom_range(12, 1)), 2, 0, 0, 6, 400);

    // Reset while draining with two outstanding transactions.
    rdy_mode = 0; rdy_delay = 0; dly_min = 20; dly_max = 20;
    go_req = 1; go_num = 2;
    cycle();
    for (int i = 0; i < 10 && acc_cnt < 2; i++) cycle();
    chk("drain_outstanding", acc_cnt - done_cnt, 2);
    chk("drain_state", dbg_state, 32'(DRAIN));
    #2;
    apply_reset();
    for (int i = 0; i < 25; i++) cycle();

    // Normal run after the abort.
    run(1, 0, 0, 3, 3, 20);
    chk("post_reset_txn_done", txn_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
